// File: rtl/clock_input_cond.sv
// Alarm-clock input conditioner: six synchronized, debounced control levels
// plus a 1 Hz Pulse square wave and a one-cycle Tick strobe from a prescaler.

module clock_input_cond_chan #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic fall
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          s;
    logic          done;

    assign s    = sync[1];
    assign done = (s != lvl) && (cnt == CMAX);
    // level flips 1->0 on this edge; lets the prescaler restart in the same cycle
    assign fall = done && lvl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            lvl  <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (s == lvl) begin
                cnt <= '0;
            end else if (done) begin
                lvl <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module clock_input_cond #(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic Reset_raw,
    input  logic Timeset_raw,
    input  logic Alarmset_raw,
    input  logic Minadv_raw,
    input  logic Hrsadv_raw,
    input  logic Alarmon_raw,
    output logic Reset,
    output logic Timeset,
    output logic Alarmset,
    output logic Minadv,
    output logic Hrsadv,
    output logic Alarmon,
    output logic Pulse,
    output logic Tick
);
    localparam int NUM_LANES = 6;
    localparam int NW = $clog2(TICK_DIV);
    localparam logic [NW-1:0] NMAX = NW'(TICK_DIV - 1);
    localparam logic [NW-1:0] HALF = NW'(TICK_DIV / 2);

    logic [NUM_LANES-1:0] raw_vec;
    logic [NUM_LANES-1:0] lvl_vec;
    logic [NUM_LANES-1:0] fall_vec;
    logic                 unused_falls;

    assign raw_vec = {Alarmon_raw, Hrsadv_raw, Minadv_raw,
                      Alarmset_raw, Timeset_raw, Reset_raw};
    assign {Alarmon, Hrsadv, Minadv, Alarmset, Timeset, Reset} = lvl_vec;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            clock_input_cond_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_vec[g]),
                .lvl  (lvl_vec[g]),
                .fall (fall_vec[g])
            );
        end
    endgenerate

    // only the Reset lane's falling edge drives the prescaler
    assign unused_falls = ^fall_vec[NUM_LANES-1:1];

    logic [NW-1:0] n;
    logic [NW-1:0] n_nxt;
    logic          restart;
    logic          wrap;

    assign restart = fall_vec[0];
    assign wrap    = (n == NMAX);

    always_comb begin
        n_nxt = n + NW'(1);
        if (restart || wrap) n_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n     <= '0;
            Pulse <= 1'b0;
            Tick  <= 1'b0;
        end else begin
            n     <= n_nxt;
            Pulse <= (n_nxt < HALF);
            Tick  <= wrap && !restart;
        end
    end
endmodule

// File: tb/tb_clock_input_cond.sv
// Randomized bench for clock_input_cond against a window-based reference model.

module tb_clock_input_cond;
    localparam int TD = 8;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [5:0] raw = '0;
    logic Reset, Timeset, Alarmset, Minadv, Hrsadv, Alarmon, Pulse, Tick;
    logic [5:0] outs;

    always #5 clk = ~clk;

    clock_input_cond #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst),
        .Reset_raw(raw[0]), .Timeset_raw(raw[1]), .Alarmset_raw(raw[2]),
        .Minadv_raw(raw[3]), .Hrsadv_raw(raw[4]), .Alarmon_raw(raw[5]),
        .Reset(Reset), .Timeset(Timeset), .Alarmset(Alarmset),
        .Minadv(Minadv), .Hrsadv(Hrsadv), .Alarmon(Alarmon),
        .Pulse(Pulse), .Tick(Tick)
    );

    assign outs = {Alarmon, Hrsadv, Minadv, Alarmset, Timeset, Reset};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // reference: a level flips once the last DB synchronized samples all
    // disagree with it; synchronized sample at edge e is raw captured at e-2
    logic [5:0] hist[$];
    logic [5:0] m_lvl;
    int         m_n;
    bit         m_pulse, m_tick, m_restart;
    int         ecnt;

    function automatic void m_reset();
        m_lvl = '0; m_n = 0; m_pulse = 0; m_tick = 0; m_restart = 0;
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(6'd0);
    endfunction

    function automatic void m_edge();
        logic [5:0] nl;
        bit all;
        nl = m_lvl;
        hist.push_back(raw);
        void'(hist.pop_front());
        for (int ch = 0; ch < 6; ch++) begin
            all = 1;
            for (int k = 0; k < DB; k++) if (hist[k][ch] == m_lvl[ch]) all = 0;
            if (all) nl[ch] = ~m_lvl[ch];
        end
        m_restart = m_lvl[0] && !nl[0];
        m_tick    = !m_restart && (m_n == TD - 1);
        m_n       = m_restart ? 0 : (m_n + 1) % TD;
        m_pulse   = (m_n < TD / 2);
        m_lvl     = nl;
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_edge();
            ecnt++;
        end
        @(negedge clk);
        chk("levels", outs, m_lvl);
        chk("pulse", Pulse, m_pulse);
        chk("tick", Tick, m_tick);
    endtask

    task automatic arst_pulse();
        #1 rst = 1'b0;
        #1 chk("arst_outs", {outs, Pulse, Tick}, 8'd0);
        m_reset();
        ecnt = 0;
        #1 rst = 1'b1;
    endtask

    task automatic wait_n(input int target);
        int guard = 0;
        while (m_n != target && guard < 20) begin
            step();
            guard++;
        end
        chk("wait_n", m_n, target);
    endtask

    task automatic restart_at(input int pre_n, input string tag);
        raw[0] = 1'b1;
        repeat (12) step();
        chk({tag, "_held"}, Reset, 1'b1);
        // drop now: level falls 6 edges later, when pre-edge n = m_n+5
        wait_n((pre_n + TD - 5) % TD);
        raw[0] = 1'b0;
        repeat (6) step();
        chk({tag, "_fall"}, Reset, 1'b0);
        chk({tag, "_pulse"}, Pulse, 1'b1);
        chk({tag, "_tick"}, Tick, 1'b0);
        repeat (7) step();
        chk({tag, "_notick7"}, Tick, 1'b0);
        step();
        chk({tag, "_tick8"}, Tick, 1'b1);
    endtask

    int hold[6];

    initial begin
        m_reset();
        ecnt = 0;
        // power-on: three cycles in reset, release before edge 1
        repeat (3) step();
        chk("por_outs", {outs, Pulse, Tick}, 8'd0);
        rst = 1'b1;
        repeat (3) step();
        chk("por_pulse_e3", Pulse, 1'b1);
        step();
        chk("por_pulse_e4", Pulse, 1'b0);
        repeat (4) step();
        chk("por_e8", {Pulse, Tick}, 2'b11);

        // clean press on Minadv before edge 20
        while (ecnt < 19) step();
        raw[3] = 1'b1;
        repeat (5) step();
        chk("minadv_e24", Minadv, 1'b0);
        step();
        chk("minadv_e25", Minadv, 1'b1);

        // bounce on Hrsadv: edges 33-35 high, 36 low, 37-38 high, 39 low, 40+ high
        while (ecnt < 32) step();
        for (int e = 33; e <= 44; e++) begin
            raw[4] = !(e == 36 || e == 39);
            step();
            chk("hrsadv_bounce", Hrsadv, 1'b0);
        end
        step();
        chk("hrsadv_e45", Hrsadv, 1'b1);

        restart_at(5, "rst_n5");
        restart_at(7, "rst_n7");

        // async reset mid-operation
        raw[5] = 1'b1;
        repeat (10) step();
        chk("alarmon_set", Alarmon, 1'b1);
        wait_n(3);
        raw[1] = ~raw[1];
        repeat (3) step();
        chk("mid_n6", m_n, 6);
        arst_pulse();
        repeat (12) step();
        chk("alarmon_redb", Alarmon, 1'b1);

        // randomized runs of varying length on every input
        for (int ch = 0; ch < 6; ch++) hold[ch] = $urandom_range(1, 3 * DB);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int ch = 0; ch < 6; ch++) begin
                hold[ch]--;
                if (hold[ch] <= 0) begin
                    raw[ch] = ~raw[ch];
                    hold[ch] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, DB)
                                                          : $urandom_range(DB, 4 * DB);
                end
            end
            if ($urandom_range(0, 499) == 0) arst_pulse();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
